// File: rtl/dcim_pkg.sv
// Shared types and defaults for the bit-serial DCIM accumulator.
// Holds the FSM state encoding and the accumulator width derivation.
package dcim_pkg;

  localparam int DEF_MAC_W   = 15;
  localparam int DEF_IN_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // One extra bit per shift is enough to hold any sum of IN_BITS weighted planes.
  function automatic int acc_width(input int mac_w, input int in_bits);
    return mac_w + in_bits;
  endfunction

endpackage

// File: rtl/dcim_bitserial_acc.sv
// Shift-and-add combiner of MSB-first bit-plane partial sums into one dot-product result,
// with negative MSB weighting in signed mode and a valid/ready result handshake.
module dcim_bitserial_acc
  import dcim_pkg::*;
#(
  parameter int MAC_W   = DEF_MAC_W,
  parameter int IN_BITS = DEF_IN_BITS,
  parameter int ACC_W   = acc_width(MAC_W, IN_BITS),
  parameter int CNT_W   = $clog2(IN_BITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sus,
  input  logic             clear,
  input  logic             mac_valid,
  input  logic [MAC_W-1:0] mac_in,
  output logic             busy,
  output logic [CNT_W-1:0] bit_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_BITS - 1);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q, acc_d, acc_out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sus_q, out_valid_q;
  logic [ACC_W-1:0] ext;

  assign ext = sus_q ? {{(ACC_W-MAC_W){mac_in[MAC_W-1]}}, mac_in}
                     : {{(ACC_W-MAC_W){1'b0}}, mac_in};

  // The first (MSB) plane of a signed activation carries weight -2^(IN_BITS-1).
  always_comb begin
    acc_d = (acc_q << 1) + ext;
    if (cnt_q == '0 && sus_q) begin
      acc_d = '0 - ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sus_q       <= 1'b0;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
    end else if (clear) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            sus_q   <= sus;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (mac_valid) begin
            acc_q <= acc_d;
            if (cnt_q == LAST_CNT) begin
              cnt_q       <= '0;
              acc_out_q   <= acc_d;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
  assign bit_idx   = LAST_CNT - cnt_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;

endmodule

// File: tb/tb_dcim_bitserial_acc.sv
// Randomized self-checking bench for dcim_bitserial_acc against a weighted-sum reference.
// Directed cases cover reset, clear, stalls, backpressure and signed MSB weighting.
module tb_dcim_bitserial_acc;

  localparam int MAC_W   = 15;
  localparam int IN_BITS = 8;
  localparam int ACC_W   = 23;
  localparam int CNT_W   = 3;

  typedef logic [MAC_W-1:0] planes_t [IN_BITS];

  logic             clk = 1'b0;
  logic             rst_n, start, sus, clear, mac_valid, out_ready;
  logic [MAC_W-1:0] mac_in;
  logic             busy, out_valid;
  logic [CNT_W-1:0] bit_idx;
  logic [ACC_W-1:0] acc_out;

  int n_tests = 0;
  int n_fail  = 0;

  dcim_bitserial_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sus       (sus),
    .clear     (clear),
    .mac_valid (mac_valid),
    .mac_in    (mac_in),
    .busy      (busy),
    .bit_idx   (bit_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Dot product as plain arithmetic: beat p carries plane IN_BITS-1-p with weight 2^plane,
  // negated for the top plane when signed.
  function automatic logic [ACC_W-1:0] model(input bit s, input planes_t m);
    longint sum = 0;
    for (int p = 0; p < IN_BITS; p++) begin
      int     plane = IN_BITS - 1 - p;
      longint v     = s ? longint'($signed(m[p])) : longint'(m[p]);
      longint w     = longint'(1) << plane;
      if (s && plane == IN_BITS - 1) w = -w;
      sum += v * w;
    end
    return ACC_W'(sum);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string name, input bit s, input planes_t m, input int gap_max,
                       input int rdy_delay, input bit start_in_done);
    logic [ACC_W-1:0] exp;
    exp = model(s, m);
    start = 1'b1;
    sus   = s;
    tick();
    start = 1'b0;
    sus   = ~s;
    chk({name, " busy"}, 32'(busy), 32'd1);
    for (int p = 0; p < IN_BITS; p++) begin
      int g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        mac_valid = 1'b0;
        mac_in    = MAC_W'($urandom);
        tick();
      end
      chk({name, " bit_idx"}, 32'(bit_idx), 32'(IN_BITS - 1 - p));
      chk({name, " early_valid"}, 32'(out_valid), 32'd0);
      mac_valid = 1'b1;
      mac_in    = m[p];
      tick();
    end
    mac_valid = 1'b0;
    mac_in    = MAC_W'($urandom);
    chk({name, " out_valid"}, 32'(out_valid), 32'd1);
    chk({name, " acc_out"}, 32'(acc_out), 32'(exp));
    for (int k = 0; k < rdy_delay; k++) begin
      start = start_in_done;
      tick();
      chk({name, " hold_valid"}, 32'(out_valid), 32'd1);
      chk({name, " hold_acc"}, 32'(acc_out), 32'(exp));
    end
    out_ready = 1'b1;
    start     = start_in_done;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk({name, " valid_drop"}, 32'(out_valid), 32'd0);
    chk({name, " idle"}, 32'(busy), 32'd0);
    chk({name, " acc_kept"}, 32'(acc_out), 32'(exp));
    tick();
    chk({name, " no_restart"}, 32'(busy), 32'd0);
  endtask

  task automatic partial(input planes_t m, input int beats);
    start = 1'b1;
    sus   = 1'b0;
    tick();
    start = 1'b0;
    for (int p = 0; p < beats; p++) begin
      mac_valid = 1'b1;
      mac_in    = m[p];
      tick();
    end
    mac_valid = 1'b0;
  endtask

  initial begin
    planes_t m;
    logic [ACC_W-1:0] last;
    rst_n = 1'b0; start = 1'b0; sus = 1'b0; clear = 1'b0;
    mac_valid = 1'b0; out_ready = 1'b0; mac_in = '0;
    #2;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst acc_out", 32'(acc_out), 32'd0);
    chk("rst bit_idx", 32'(bit_idx), 32'd7);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of an operation, then a clean unsigned op.
    foreach (m[i]) m[i] = 15'h0001;
    partial(m, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst bit_idx", 32'(bit_idx), 32'd7);
    tick();
    rst_n = 1'b1;
    tick();
    do_op("ones", 1'b0, m, 0, 0, 1'b0);
    chk("ones const", 32'(acc_out), 32'h0000FF);

    foreach (m[i]) m[i] = 15'h7FFF;
    do_op("usat", 1'b0, m, 0, 1, 1'b0);
    chk("usat const", 32'(acc_out), 32'h7F7F01);

    foreach (m[i]) m[i] = '0;
    m[0] = 15'h0001;
    do_op("smsb", 1'b1, m, 0, 0, 1'b0);
    chk("smsb const", 32'(acc_out), 32'h7FFF80);

    foreach (m[i]) m[i] = 15'h7FFF;
    do_op("sneg", 1'b1, m, 0, 0, 1'b0);
    chk("sneg const", 32'(acc_out), 32'h000001);

    foreach (m[i]) m[i] = '0;
    m[0] = 15'h7FFF;
    do_op("sneg7", 1'b1, m, 0, 0, 1'b0);
    chk("sneg7 const", 32'(acc_out), 32'h000080);

    // Stall and backpressure with a start attempted during DONE.
    foreach (m[i]) m[i] = 15'h0001;
    do_op("stall", 1'b0, m, 3, 5, 1'b1);
    chk("stall const", 32'(acc_out), 32'h0000FF);
    last = acc_out;

    // Abort at cnt=5 with a live beat and a start in the same cycle.
    foreach (m[i]) m[i] = MAC_W'($urandom);
    partial(m, 5);
    clear = 1'b1; mac_valid = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; mac_valid = 1'b0; start = 1'b0;
    chk("clear busy", 32'(busy), 32'd0);
    chk("clear bit_idx", 32'(bit_idx), 32'd7);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("clear no_valid", 32'(out_valid), 32'd0);
    end
    chk("clear acc_kept", 32'(acc_out), 32'(last));
    foreach (m[i]) m[i] = '0;
    do_op("szero", 1'b1, m, 1, 0, 1'b0);
    chk("szero const", 32'(acc_out), 32'h000000);

    for (int t = 0; t < 25; t++) begin
      bit s = 1'($urandom);
      foreach (m[i]) m[i] = MAC_W'($urandom);
      do_op($sformatf("rand%0d", t), s, m, 2, int'($urandom_range(3, 0)),
            1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcim_bitserial_acc.md
Name: dcim_bitserial_acc

Overview:
Shift-and-add accumulator that sits directly downstream of the local MAC column. Input activations are applied one bit-plane per step, MSB first, and each step yields a 15-bit partial sum. This block combines IN_BITS successive partial sums into one full-precision dot-product result, applying two's-complement weighting to the MSB plane in signed mode. It also drives the bit-plane index to the upstream input driver and hands the result downstream with a valid/ready handshake.

Parameters:
MAC_W, 15, width of the incoming partial sum (mac_in).
IN_BITS, 8, activation precision, i.e. bit-planes per operation (>=2).
ACC_W, MAC_W+IN_BITS (23), accumulator and result width. This width cannot overflow for any input.
CNT_W, $clog2(IN_BITS) (3), width of the bit-plane counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  single-cycle request to begin an operation; honoured only in IDLE.
sus  input  1  1 = signed activations/weights, 0 = unsigned; sampled with start.
clear  input  1  synchronous abort; forces IDLE from any state.
mac_valid  input  1  mac_in holds the partial sum for the current bit-plane.
mac_in  input  MAC_W  partial sum from the local MAC (two's complement when sus_q=1).
busy  output  1  high in ACCUM and DONE.
bit_idx  output  CNT_W  activation bit-plane the upstream driver must present; IN_BITS-1 down to 0.
out_valid  output  1  acc_out is valid.
out_ready  input  1  downstream accepts acc_out.
acc_out  output  ACC_W  final accumulated result, two's complement when sus_q=1.

Behaviour:
- Reset (rst_n low, async): state=IDLE, acc=0, cnt=0, sus_q=0. Outputs: busy=0, out_valid=0, acc_out=0, bit_idx=IN_BITS-1.
- FSM states: IDLE, ACCUM, DONE. The FSM is registered and all outputs are registered or decoded from state.
- IDLE:
  - On start=1: latch sus_q=sus, set acc=0 and cnt=0, then go to ACCUM.
  - mac_valid is ignored in IDLE.
- ACCUM:
  - bit_idx = IN_BITS-1-cnt.
  - On mac_valid=1, extend mac_in to ACC_W as ext. Use sign extension if sus_q=1 and zero extension otherwise.
  - If cnt==0 and sus_q=1: acc <= -ext (MSB plane carries negative weight).
  - Otherwise: acc <= (acc<<1) + ext. Arithmetic is modulo 2^ACC_W.
  - After the update, cnt increments.
  - On the mac_valid beat with cnt==IN_BITS-1: acc_out <= the final value, out_valid <= 1, go to DONE.
  - mac_valid=0 stalls the operation: no change to state, acc or cnt. Gaps of any length are legal.
- DONE:
  - out_valid=1 and acc_out are held stable until out_ready=1.
  - On out_ready=1: out_valid <= 0 next cycle, return to IDLE. acc_out keeps its value.
  - mac_valid is ignored in DONE.
- start outside IDLE is ignored, including a start in the same cycle as the handshake. Back-to-back operations therefore have at least one IDLE cycle between them.
- Latency: the result is valid one cycle after the last mac_valid beat. The minimum operation is 1 start cycle plus IN_BITS beats.
- clear=1: next state is IDLE, out_valid <= 0, acc and cnt reset to 0. clear has priority over start, mac_valid and out_ready. acc_out is not cleared.
- rst_n asserted mid-operation: immediate return to the reset values and no output is produced.
- sus changing after start has no effect until the next start.

Decomposition:
- Shared package dcim_pkg holds:
  - the FSM state enum (IDLE/ACCUM/DONE);
  - the MAC_W and IN_BITS defaults;
  - the ACC_W derivation.
- No sub-module. The shift-add datapath and the FSM are small enough to live in one module.

Test Plan:
- Reset mid-ACCUM after 3 beats: drop rst_n, then start a new op, sus=0, mac_in=15'h0001 for all 8 beats. Expect busy drops immediately, out_valid=0, and the new result is acc_out=23'h0000FF.
- Unsigned saturating case: sus=0, mac_in=15'h7FFF for all 8 beats. Expect acc_out=23'h7F7F01, out_valid 1 cycle after the last beat, bit_idx sequence 7..0.
- Signed MSB only: sus=1, mac_in=15'h0001 on plane 7, 0 on planes 6..0. Expect acc_out=23'h7FFF80 (-128).
- Signed negative partials: sus=1, mac_in=15'h7FFF (-1) on all 8 planes. Expect acc_out=23'h000001. With 15'h7FFF on plane 7 only, expect 23'h000080.
- Stall and backpressure: unsigned all-ones-LSB stream (result 23'h0000FF) with mac_valid deasserted for 3 cycles between beats 2 and 3, and out_ready held low 5 cycles. Expect the result unchanged and acc_out stable while out_valid=1. A start issued during DONE is ignored.
- clear at cnt=5: expect IDLE next cycle, out_valid never asserts, busy=0. A following signed op with mac_in=0 on all planes yields acc_out=23'h000000.
